// File: rtl/s2p_pkg.sv
// Shared types and defaults for the S2P deserializer arbiter.
package s2p_pkg;

  // Arbiter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int DEF_NCH = 4;
  localparam int DEF_DW  = 22;

  // Width of an index able to address n items (minimum 1 bit).
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker: first set request at or above
// ptr, wrapping at NCH.
module rr_pick
  import s2p_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int CW  = clog2w(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  ptr,
  output logic [NCH-1:0] onehot,
  output logic [CW-1:0]  idx,
  output logic           any
);

  // Scan NCH positions starting at ptr; the first hit wins.
  always_comb begin
    int unsigned pos;
    // NOTE: every output gets a default before the loop so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    pos    = 0;
    for (int i = 0; i < NCH; i++) begin
      pos = (int'(ptr) + i) % NCH;
      if (!any && req[pos]) begin
        any         = 1'b1;
        onehot[pos] = 1'b1;
        idx         = CW'(pos);
      end
    end
  end

endmodule

// File: rtl/s2p_arbiter.sv
// Shares one S2P deserializer among NCH serial requesters with round-robin
// arbitration, a single result buffer and a done watchdog.
module s2p_arbiter
  import s2p_pkg::*;
#(
  parameter int NCH     = DEF_NCH,
  parameter int CW      = clog2w(NCH),
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] ch_req,
  input  logic [NCH-1:0] ch_din,
  output logic [NCH-1:0] ch_gnt,
  output logic           s2p_start,
  output logic           s2p_din,
  input  logic [DW-1:0]  s2p_dout,
  input  logic           s2p_done,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CW-1:0]  out_ch,
  output logic [DW-1:0]  out_data,
  output logic           err_timeout
);

  state_t          state_q, state_d;
  logic [CW-1:0]   rr_ptr;
  logic [CW-1:0]   gnt_idx;
  logic [TW-1:0]   wdog;

  logic [NCH-1:0]  pick_onehot;
  logic [CW-1:0]   pick_idx;
  logic            pick_any;

  logic            do_grant;
  logic            do_capture;
  logic            do_abort;

  rr_pick #(.NCH(NCH), .CW(CW)) u_pick (
    .req    (ch_req),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Next-state and one-cycle control strobes; done beats the watchdog.
  always_comb begin
    state_d    = state_q;
    do_grant   = 1'b0;
    do_capture = 1'b0;
    do_abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          do_grant = 1'b1;
          state_d  = START;
        end
      end
      START: state_d = BUSY;
      BUSY: begin
        if (s2p_done) begin
          do_capture = 1'b1;
          state_d    = OUT;
        end else if (wdog == TW'(TIMEOUT - 1)) begin
          do_abort = 1'b1;
          state_d  = IDLE;
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Grant, round-robin pointer, watchdog and result buffer.
  always_ff @(posedge clk) begin
    // NOTE: the result buffer is a plain register, not a memory, so it is
    // cleared on reset along with the control state.
    if (rst) begin
      rr_ptr      <= '0;
      ch_gnt      <= '0;
      gnt_idx     <= '0;
      wdog        <= '0;
      err_timeout <= 1'b0;
      out_ch      <= '0;
      out_data    <= '0;
    end else begin
      err_timeout <= do_abort;
      if (do_grant) begin
        ch_gnt  <= pick_onehot;
        gnt_idx <= pick_idx;
        rr_ptr  <= (pick_idx == CW'(NCH - 1)) ? '0 : pick_idx + CW'(1);
      end
      if (do_capture || do_abort) ch_gnt <= '0;
      if (do_capture) begin
        out_data <= s2p_dout;
        out_ch   <= gnt_idx;
      end
      if (state_q == START)                wdog <= '0;
      else if (state_q == BUSY && !s2p_done) wdog <= wdog + TW'(1);
    end
  end

  assign s2p_start = (state_q == START);
  assign out_valid = (state_q == OUT);
  assign s2p_din   = (state_q == START || state_q == BUSY) ? ch_din[gnt_idx] : 1'b0;

endmodule

// File: tb/tb_s2p_arbiter.sv
// Directed bench for s2p_arbiter with a stub deserializer.
module tb_s2p_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ch_req, ch_din, ch_gnt;
  logic        s2p_start, s2p_din, s2p_done;
  logic [21:0] s2p_dout, out_data;
  logic        out_valid, out_ready, err_timeout;
  logic [1:0]  out_ch;

  int n_vec = 0;
  int n_bad = 0;

  s2p_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .ch_req     (ch_req),
    .ch_din     (ch_din),
    .ch_gnt     (ch_gnt),
    .s2p_start  (s2p_start),
    .s2p_din    (s2p_din),
    .s2p_dout   (s2p_dout),
    .s2p_done   (s2p_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ch     (out_ch),
    .out_data   (out_data),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Wait (bounded) for the START cycle; called and returns at a negedge.
  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (s2p_start === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    check("start_wait_expired", 32'd0, 32'd1);
  endtask

  // Stub deserializer: done in BUSY cycle lat; ends at a negedge in OUT.
  task automatic do_xfer(input int lat, input logic [21:0] dout, input int exp_ch,
                         input bit drop_req, input bit mux_chk);
    bit ok;
    int starts;
    wait_start(ok);
    if (!ok) return;
    check("gnt_at_start", 32'(ch_gnt), 32'(1 << exp_ch));
    if (drop_req) ch_req[exp_ch] = 1'b0;
    starts = 0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (s2p_start) starts++;
      if (mux_chk) begin
        ch_din = (k % 2 == 1) ? 4'b0010 : 4'b1101;
        #1;
        check("s2p_din_mux", 32'(s2p_din), 32'(k % 2));
      end
      if (k == lat) begin
        s2p_done = 1'b1;
        s2p_dout = dout;
      end
    end
    @(negedge clk);
    s2p_done = 1'b0;
    s2p_dout = '0;
    check("extra_start", 32'(starts), 32'd0);
    check("out_valid", 32'(out_valid), 32'd1);
    check("out_ch", 32'(out_ch), 32'(exp_ch));
    check("out_data", 32'(out_data), 32'(dout));
    check("gnt_clear", 32'(ch_gnt), 32'd0);
    check("no_err", 32'(err_timeout), 32'd0);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_dropped", 32'(out_valid), 32'd0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_gnt", 32'(ch_gnt), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_start", 32'(s2p_start), 32'd0);
  endtask

  initial begin
    bit ok;
    int cnt;
    bit seen_valid;
    logic [21:0] held;

    rst = 1'b1; ch_req = '0; ch_din = '0; s2p_dout = '0; s2p_done = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    // Reset state.
    check("r_gnt", 32'(ch_gnt), 32'd0);
    check("r_start", 32'(s2p_start), 32'd0);
    check("r_valid", 32'(out_valid), 32'd0);
    check("r_err", 32'(err_timeout), 32'd0);
    check("r_ch", 32'(out_ch), 32'd0);
    check("r_data", 32'(out_data), 32'd0);
    check("r_din", 32'(s2p_din), 32'd0);
    rst = 1'b0;

    // Single request on channel 2, result held under backpressure.
    ch_req = 4'b0100;
    do_xfer(23, 22'h2A5A5A, 2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("single_hold_valid", 32'(out_valid), 32'd1);
      check("single_hold_data", 32'(out_data), 32'h2A5A5A);
    end
    accept();

    // Serial mux on channel 1 (pointer now 3, wraps to 1); 0 while IDLE.
    ch_din = 4'b1111;
    @(negedge clk);
    check("din_idle_zero", 32'(s2p_din), 32'd0);
    ch_req = 4'b0010;
    do_xfer(8, 22'h155AA3, 1, 1'b1, 1'b1);
    ch_din = '0;
    accept();

    // Done while idle is ignored.
    s2p_done = 1'b1;
    s2p_dout = 22'h3FFFFF;
    @(negedge clk);
    s2p_done = 1'b0;
    s2p_dout = '0;
    @(negedge clk);
    check("idle_done_valid", 32'(out_valid), 32'd0);
    check("idle_done_gnt", 32'(ch_gnt), 32'd0);

    // Done on the last allowed BUSY cycle beats the watchdog (pointer 2 -> ch0).
    ch_req = 4'b0001;
    do_xfer(64, 22'h012345, 0, 1'b1, 1'b0);
    accept();

    // All channels requesting from reset: order 0,1,2,3,0.
    ch_req = 4'b1111;
    pulse_rst();
    do_xfer(3, 22'h100000, 0, 1'b0, 1'b0); accept();
    do_xfer(4, 22'h100001, 1, 1'b0, 1'b0); accept();
    do_xfer(5, 22'h100002, 2, 1'b0, 1'b0); accept();
    do_xfer(6, 22'h100003, 3, 1'b0, 1'b0); accept();
    do_xfer(3, 22'h100004, 0, 1'b0, 1'b0); accept();

    // Backpressure: channel 1 result held 10 cycles, no new grant meanwhile.
    do_xfer(5, 22'h0BEEF1, 1, 1'b0, 1'b0);
    held = out_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_gnt", 32'(ch_gnt), 32'd0);
      check("bp_start", 32'(s2p_start), 32'd0);
      check("bp_data", 32'(out_data), 32'h0BEEF1);
    end
    accept();
    check("bp_after_gnt", 32'(ch_gnt), 32'd0);
    check("bp_after_start", 32'(s2p_start), 32'd0);
    @(negedge clk);
    check("bp_next_gnt", 32'(ch_gnt), 32'b0100);
    check("bp_next_start", 32'(s2p_start), 32'd1);
    do_xfer(4, 22'h222222, 2, 1'b0, 1'b0);
    accept();

    // Watchdog: channel 3 never completes.
    wait_start(ok);
    check("to_gnt", 32'(ch_gnt), 32'b1000);
    cnt = 0;
    seen_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cnt++;
      if (out_valid) seen_valid = 1'b1;
      if (err_timeout) break;
    end
    check("to_cycles", 32'(cnt), 32'd65);
    check("to_gnt_clear", 32'(ch_gnt), 32'd0);
    check("to_no_valid", 32'(seen_valid), 32'd0);
    @(negedge clk);
    check("to_err_one_cycle", 32'(err_timeout), 32'd0);
    check("to_next_gnt", 32'(ch_gnt), 32'b0001);
    ch_req = 4'b0000;
    do_xfer(6, 22'h3C3C3C, 0, 1'b0, 1'b0);
    accept();

    // Reset mid-BUSY on channel 3, then 1001 goes to channel 0.
    ch_req = 4'b1000;
    wait_start(ok);
    check("rb3_gnt", 32'(ch_gnt), 32'b1000);
    ch_req = 4'b0000;
    repeat (5) @(negedge clk);
    pulse_rst();
    ch_req = 4'b1001;
    do_xfer(3, 22'h0A0A0A, 0, 1'b1, 1'b0);
    ch_req = 4'b0000;
    accept();

    // Reset mid-BUSY on channel 1 must also clear the pointer: 0101 -> ch0.
    ch_req = 4'b0010;
    wait_start(ok);
    check("rb1_gnt", 32'(ch_gnt), 32'b0010);
    ch_req = 4'b0000;
    repeat (3) @(negedge clk);
    pulse_rst();
    ch_req = 4'b0101;
    do_xfer(3, 22'h050505, 0, 1'b1, 1'b0);
    ch_req = 4'b0000;
    accept();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
